// File: rtl/key_voice_allocator_pkg.sv
// Shared defaults and types for the key-to-voice allocator.
package key_voice_allocator_pkg;

  localparam int DEF_NUM_KEYS   = 8;
  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_KEY_W      = 3;
  localparam int DEF_AGE_W      = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/key_voice_allocator_lsb_pick.sv
// Lowest-set-bit picker: one-hot of the lowest set bit, its index, and any-set flag.
module lsb_pick #(
  parameter int W  = 8,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [W-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = |vec;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
      end
    end
  end

endmodule

// File: rtl/key_voice_allocator.sv
// Assigns pressed keys to a small pool of tone-generator voices, one event per clock,
// stealing the oldest voice when the pool is exhausted.
module key_voice_allocator
  import key_voice_allocator_pkg::*;
#(
  parameter int NUM_KEYS   = DEF_NUM_KEYS,
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int KEY_W      = DEF_KEY_W,
  parameter int AGE_W      = DEF_AGE_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_KEYS-1:0]         key_press,
  input  logic [NUM_KEYS-1:0]         key_release,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]       voice_start,
  output logic [NUM_VOICES-1:0]       voice_stop,
  output logic                        steal,
  output logic                        busy
);

  localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  alloc_state_t state, state_nxt;

  logic [NUM_KEYS-1:0]   pend_press, pend_release;
  logic [NUM_KEYS-1:0]   pend_press_nxt, pend_release_nxt;
  logic [KEY_W-1:0]      keys [NUM_VOICES];
  logic [AGE_W-1:0]      ages [NUM_VOICES];

  logic [NUM_KEYS-1:0]   rel_oh, prs_oh;
  logic [KEY_W-1:0]      rel_idx, prs_idx;
  logic                  rel_valid, prs_valid;
  logic [NUM_VOICES-1:0] free_oh;
  logic [VOICE_W-1:0]    free_idx;
  logic                  free_valid;

  logic                  do_release, do_press;
  logic [KEY_W-1:0]      target_key;
  logic                  match_valid;
  logic [VOICE_W-1:0]    match_idx, oldest_idx, press_voice;
  logic [NUM_VOICES-1:0] match_oh, oldest_oh, press_oh;
  logic [AGE_W-1:0]      oldest_age;
  logic                  press_steal;

  lsb_pick #(.W(NUM_KEYS), .IW(KEY_W)) u_pick_release (
    .vec    (pend_release),
    .onehot (rel_oh),
    .idx    (rel_idx),
    .valid  (rel_valid)
  );

  lsb_pick #(.W(NUM_KEYS), .IW(KEY_W)) u_pick_press (
    .vec    (pend_press),
    .onehot (prs_oh),
    .idx    (prs_idx),
    .valid  (prs_valid)
  );

  lsb_pick #(.W(NUM_VOICES), .IW(VOICE_W)) u_pick_free (
    .vec    (~voice_active),
    .onehot (free_oh),
    .idx    (free_idx),
    .valid  (free_valid)
  );

  assign busy = (|pend_press) | (|pend_release);

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_key_out
    assign voice_key[g*KEY_W +: KEY_W] = keys[g];
  end

  // Releases always beat presses; a fresh pulse on the serviced bit keeps it pending.
  always_comb begin
    state_nxt  = state;
    do_release = 1'b0;
    do_press   = 1'b0;
    if (state == ST_SERVE) begin
      do_release = rel_valid;
      do_press   = !rel_valid && prs_valid;
    end
    pend_release_nxt = (pend_release & ~(do_release ? rel_oh : '0)) | key_release;
    pend_press_nxt   = (pend_press   & ~(do_press   ? prs_oh : '0)) | key_press;
    case (state)
      ST_IDLE:  if ((|pend_release_nxt) || (|pend_press_nxt)) state_nxt = ST_SERVE;
      ST_SERVE: if (!(|pend_release_nxt) && !(|pend_press_nxt)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Voice lookup for the event being serviced: holder of the key, else free, else oldest.
  always_comb begin
    target_key  = do_release ? rel_idx : prs_idx;
    match_valid = 1'b0;
    match_idx   = '0;
    match_oh    = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (voice_active[v] && keys[v] == target_key) begin
        match_valid = 1'b1;
        match_idx   = VOICE_W'(v);
        match_oh    = '0;
        match_oh[v] = 1'b1;
      end
    end
    oldest_idx   = '0;
    oldest_age   = ages[0];
    oldest_oh    = '0;
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (ages[v] > oldest_age) begin
        oldest_idx = VOICE_W'(v);
        oldest_age = ages[v];
      end
    end
    oldest_oh[oldest_idx] = 1'b1;
    press_steal = 1'b0;
    if (match_valid) begin
      press_voice = match_idx;
      press_oh    = match_oh;
    end else if (free_valid) begin
      press_voice = free_idx;
      press_oh    = free_oh;
    end else begin
      press_voice = oldest_idx;
      press_oh    = oldest_oh;
      press_steal = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pend_press   <= '0;
      pend_release <= '0;
      voice_active <= '0;
      voice_start  <= '0;
      voice_stop   <= '0;
      steal        <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        keys[v] <= '0;
        ages[v] <= '0;
      end
    end else begin
      state        <= state_nxt;
      pend_press   <= pend_press_nxt;
      pend_release <= pend_release_nxt;
      voice_start  <= '0;
      voice_stop   <= '0;
      steal        <= 1'b0;
      if (do_release && match_valid) begin
        voice_active[match_idx] <= 1'b0;
        voice_stop[match_idx]   <= 1'b1;
        ages[match_idx]         <= '0;
      end
      // Every other sounding voice grows one step older on each press.
      if (do_press) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (voice_active[v] && !press_oh[v] && ages[v] != AGE_MAX) begin
            ages[v] <= ages[v] + 1'b1;
          end
        end
        voice_active[press_voice] <= 1'b1;
        keys[press_voice]         <= prs_idx;
        ages[press_voice]         <= '0;
        voice_start[press_voice]  <= 1'b1;
        steal                     <= press_steal;
      end
    end
  end

endmodule
